// File: rtl/klein_arbiter.sv
// klein_arbiter
// Shares a single KLEIN-64 encryption core between two requesters. A
// round-robin grant selects one pending request, its operands are
// registered onto the core inputs, the core is started with a one-cycle
// pulse, and the arbiter waits for the rising edge of core_ready. The
// ciphertext is then offered on the response port until it is
// acknowledged. A watchdog turns a core that never completes into an
// error response so the arbiter cannot lock up.
//
// Ports
//   ck, rst                        clock, asynchronous active-high reset
//   req0_valid/pt/key, req0_ready  requester 0 (ready = one-cycle accept)
//   req1_valid/pt/key, req1_ready  requester 1 (ready = one-cycle accept)
//   resp_valid, resp_id, resp_ct,  response to the granted requester,
//   resp_err, resp_ack             held until resp_ack
//   core_start, core_pt, core_key  start pulse and registered operands
//   core_ready, core_ct            completion level and result from core
//   busy                           high whenever the arbiter is not idle

module klein_arbiter #(
    parameter int BLK_W   = 64,
    parameter int KEY_W   = 64,
    parameter int TIMEOUT = 128,
    parameter int TW      = 8
) (
    input  logic             ck,
    input  logic             rst,

    input  logic             req0_valid,
    input  logic [BLK_W-1:0] req0_pt,
    input  logic [KEY_W-1:0] req0_key,
    output logic             req0_ready,

    input  logic             req1_valid,
    input  logic [BLK_W-1:0] req1_pt,
    input  logic [KEY_W-1:0] req1_key,
    output logic             req1_ready,

    output logic             resp_valid,
    output logic             resp_id,
    output logic [BLK_W-1:0] resp_ct,
    output logic             resp_err,
    input  logic             resp_ack,

    output logic             core_start,
    output logic [BLK_W-1:0] core_pt,
    output logic [KEY_W-1:0] core_key,
    input  logic             core_ready,
    input  logic [BLK_W-1:0] core_ct,

    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;

    logic            last_id;
    logic            grant_id;
    logic            ready_q;
    logic [TW-1:0]   wdog;

    logic            grant_valid;
    logic            grant_sel;
    logic            core_edge;
    logic            wdog_expired;

    // Completion is only ever the low-to-high transition of core_ready, so a
    // level left over from the previous operation cannot end a new one.
    assign core_edge    = core_ready & ~ready_q;
    assign wdog_expired = (wdog == TW'(TIMEOUT - 1));

    assign resp_valid = (state == RESP);
    assign resp_id    = grant_id;
    assign busy       = (state != IDLE);

    // Next-state logic, grant selection and the single-cycle strobes.
    // When both requesters are pending, the one that was not served last
    // wins; a lone requester is served regardless of history.
    always_comb begin
        state_next  = state;
        grant_valid = 1'b0;
        grant_sel   = 1'b0;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        core_start  = 1'b0;

        case (state)
            IDLE: begin
                if (req0_valid && req1_valid) begin
                    grant_valid = 1'b1;
                    grant_sel   = ~last_id;
                end else if (req0_valid) begin
                    grant_valid = 1'b1;
                    grant_sel   = 1'b0;
                end else if (req1_valid) begin
                    grant_valid = 1'b1;
                    grant_sel   = 1'b1;
                end

                if (grant_valid) begin
                    req0_ready = ~grant_sel;
                    req1_ready = grant_sel;
                    state_next = LOAD;
                end
            end

            LOAD: begin
                core_start = 1'b1;
                state_next = RUN;
            end

            RUN: begin
                if (core_edge || wdog_expired) begin
                    state_next = RESP;
                end
            end

            RESP: begin
                if (resp_ack) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register and the one-cycle history of core_ready used for edge
    // detection. ready_q tracks core_ready in every state so the edge test
    // in the first RUN cycle already sees the level seen during LOAD.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ready_q <= 1'b0;
        end else begin
            state   <= state_next;
            ready_q <= core_ready;
        end
    end

    // Operand latch and grant bookkeeping. The core operands are only
    // written on a grant, so they stay stable through LOAD, RUN and RESP.
    // last_id resets to 1 so that requester 0 wins the first contention.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            core_pt  <= '0;
            core_key <= '0;
            grant_id <= 1'b0;
            last_id  <= 1'b1;
        end else if (grant_valid) begin
            core_pt  <= grant_sel ? req1_pt  : req0_pt;
            core_key <= grant_sel ? req1_key : req0_key;
            grant_id <= grant_sel;
            last_id  <= grant_sel;
        end
    end

    // Watchdog: cleared while the core is being started, then counts every
    // RUN cycle that does not complete. Reaching TIMEOUT-1 ends the wait.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            wdog <= '0;
        end else if (state == LOAD) begin
            wdog <= '0;
        end else if (state == RUN && !core_edge && !wdog_expired) begin
            wdog <= wdog + TW'(1);
        end
    end

    // Response capture. A completion edge takes priority over a watchdog
    // expiry in the same cycle. The result is held until the next capture,
    // which keeps it stable for the whole RESP period.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            resp_ct  <= '0;
            resp_err <= 1'b0;
        end else if (state == RUN) begin
            if (core_edge) begin
                resp_ct  <= core_ct;
                resp_err <= 1'b0;
            end else if (wdog_expired) begin
                resp_ct  <= '0;
                resp_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_klein_arbiter.sv
// tb_klein_arbiter
// Directed bench for klein_arbiter. A small behavioural core raises
// core_ready CORE_LAT cycles after core_start and holds it for 8 cycles;
// it can also be forced stuck-low or stuck-high. Outputs are sampled on
// the falling clock edge, inputs are driven right after it.

module tb_klein_arbiter;

    localparam int TIMEOUT  = 128;
    localparam int CORE_LAT = 97;

    logic        ck;
    logic        rst;
    logic        req0_valid;
    logic [63:0] req0_pt;
    logic [63:0] req0_key;
    logic        req0_ready;
    logic        req1_valid;
    logic [63:0] req1_pt;
    logic [63:0] req1_key;
    logic        req1_ready;
    logic        resp_valid;
    logic        resp_id;
    logic [63:0] resp_ct;
    logic        resp_err;
    logic        resp_ack;
    logic        core_start;
    logic [63:0] core_pt;
    logic [63:0] core_key;
    logic        core_ready = 1'b0;
    logic [63:0] core_ct    = 64'd0;
    logic        busy;

    int          checks = 0;
    int          errors = 0;

    int          core_mode = 0;
    int          lat_cnt   = 0;
    int          hold_cnt  = 0;
    logic [63:0] next_ct   = 64'd0;

    klein_arbiter #(
        .BLK_W  (64),
        .KEY_W  (64),
        .TIMEOUT(TIMEOUT),
        .TW     (8)
    ) dut (
        .ck        (ck),
        .rst       (rst),
        .req0_valid(req0_valid),
        .req0_pt   (req0_pt),
        .req0_key  (req0_key),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_pt   (req1_pt),
        .req1_key  (req1_key),
        .req1_ready(req1_ready),
        .resp_valid(resp_valid),
        .resp_id   (resp_id),
        .resp_ct   (resp_ct),
        .resp_err  (resp_err),
        .resp_ack  (resp_ack),
        .core_start(core_start),
        .core_pt   (core_pt),
        .core_key  (core_key),
        .core_ready(core_ready),
        .core_ct   (core_ct),
        .busy      (busy)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    // Core model: mode 0 behaves like the real core, mode 1 never completes,
    // mode 2 holds core_ready high permanently.
    always @(negedge ck) begin
        if (core_mode != 0) begin
            lat_cnt    = 0;
            hold_cnt   = 0;
            core_ready = (core_mode == 2);
        end else begin
            if (hold_cnt > 0) hold_cnt = hold_cnt - 1;
            if (core_start) begin
                lat_cnt = CORE_LAT;
            end else if (lat_cnt > 0) begin
                lat_cnt = lat_cnt - 1;
                if (lat_cnt == 0) begin
                    hold_cnt = 8;
                    core_ct  = next_ct;
                end
            end
            core_ready = (hold_cnt > 0);
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic [63:0] pt0,
                                 input logic v1, input logic [63:0] pt1);
        req0_valid = v0;
        req0_pt    = pt0;
        req0_key   = 64'd0;
        req1_valid = v1;
        req1_pt    = pt1;
        req1_key   = ~pt1;
    endtask

    task automatic applyReset();
        rst        = 1'b1;
        resp_ack   = 1'b0;
        applyStimulus(1'b0, 64'd0, 1'b0, 64'd0);
        @(negedge ck);
        @(negedge ck);
        rst = 1'b0;
    endtask

    // Runs one operation from grant to response, optionally acknowledging it.
    task automatic doOp(input string tag, input logic exp_id, input logic [63:0] exp_pt,
                        input logic [63:0] exp_ct, input logic exp_err, input int exp_lat,
                        input logic drop, input logic ack);
        logic got;
        logic busy_ok;
        int   lat;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (req0_ready || req1_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge ck);
        end
        if (!got) begin
            checkOutput({tag, "_grant_seen"}, 64'd0, 64'd1);
            return;
        end
        checkOutput({tag, "_grant"}, {62'd0, req1_ready, req0_ready}, exp_id ? 64'd2 : 64'd1);
        checkOutput({tag, "_idle_busy"}, busy, 64'd0);
        @(negedge ck);
        checkOutput({tag, "_start"}, core_start, 64'd1);
        checkOutput({tag, "_ready_pulse"}, {62'd0, req1_ready, req0_ready}, 64'd0);
        checkOutput({tag, "_core_pt"}, core_pt, exp_pt);
        if (drop) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end
        lat     = 0;
        busy_ok = 1'b1;
        while (!resp_valid && lat < 400) begin
            @(negedge ck);
            lat++;
            if (!busy) busy_ok = 1'b0;
        end
        checkOutput({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        checkOutput({tag, "_busy"}, busy_ok, 64'd1);
        checkOutput({tag, "_resp_id"}, resp_id, exp_id);
        checkOutput({tag, "_resp_ct"}, resp_ct, exp_ct);
        checkOutput({tag, "_resp_err"}, resp_err, exp_err);
        if (ack) begin
            resp_ack = 1'b1;
            @(negedge ck);
            resp_ack = 1'b0;
            checkOutput({tag, "_released"}, resp_valid, 64'd0);
        end
    endtask

    initial begin
        logic seen;

        rst      = 1'b1;
        resp_ack = 1'b0;
        applyStimulus(1'b0, 64'd0, 1'b0, 64'd0);
        @(negedge ck);
        @(negedge ck);
        checkOutput("reset_busy", busy, 64'd0);
        checkOutput("reset_resp_valid", resp_valid, 64'd0);
        checkOutput("reset_core_start", core_start, 64'd0);
        checkOutput("reset_core_pt", core_pt, 64'd0);
        checkOutput("reset_resp_ct", resp_ct, 64'd0);
        checkOutput("reset_ready", {62'd0, req1_ready, req0_ready}, 64'd0);

        // Single operation on requester 0.
        rst     = 1'b0;
        next_ct = 64'hCDC0B51F14722BBE;
        applyStimulus(1'b1, 64'h0123456789ABCDEF, 1'b0, 64'd0);
        doOp("single", 1'b0, 64'h0123456789ABCDEF, 64'hCDC0B51F14722BBE, 1'b0,
             CORE_LAT + 1, 1'b1, 1'b1);

        // Both requesters pending from reset: grants must alternate 0,1,0,1.
        applyReset();
        applyStimulus(1'b1, 64'hAAAA0000AAAA0000, 1'b1, 64'h5555000055550000);
        for (int op = 0; op < 4; op++) begin
            next_ct = 64'h1111000000000000 + 64'(op);
            doOp($sformatf("fair%0d", op), (op % 2) == 1,
                 (op % 2) == 1 ? 64'h5555000055550000 : 64'hAAAA0000AAAA0000,
                 64'h1111000000000000 + 64'(op), 1'b0, CORE_LAT + 1, 1'b0, 1'b1);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge ck);

        // Backpressure: response held while requester 1 waits.
        next_ct = 64'h0BADCAFE0BADCAFE;
        applyStimulus(1'b1, 64'h0000111122223333, 1'b0, 64'd0);
        doOp("bp", 1'b0, 64'h0000111122223333, 64'h0BADCAFE0BADCAFE, 1'b0,
             CORE_LAT + 1, 1'b1, 1'b0);
        req1_valid = 1'b1;
        req1_pt    = 64'h4444555566667777;
        for (int i = 0; i < 10; i++) begin
            #1;
            checkOutput($sformatf("bp_hold_ready%0d", i), req1_ready, 64'd0);
            checkOutput($sformatf("bp_hold_valid%0d", i), resp_valid, 64'd1);
            checkOutput($sformatf("bp_hold_ct%0d", i), resp_ct, 64'h0BADCAFE0BADCAFE);
            @(negedge ck);
        end
        resp_ack = 1'b1;
        @(negedge ck);
        resp_ack = 1'b0;
        #1;
        checkOutput("bp_next_grant", req1_ready, 64'd1);
        next_ct = 64'h7777666655554444;
        doOp("bp_req1", 1'b1, 64'h4444555566667777, 64'h7777666655554444, 1'b0,
             CORE_LAT + 1, 1'b1, 1'b1);

        // Core never completes: watchdog error after TIMEOUT RUN cycles.
        core_mode = 1;
        @(negedge ck);
        applyStimulus(1'b1, 64'h1234123412341234, 1'b0, 64'd0);
        doOp("timeout", 1'b0, 64'h1234123412341234, 64'd0, 1'b1, TIMEOUT + 1, 1'b1, 1'b1);

        // core_ready stuck high from before the grant is not a completion.
        core_mode = 2;
        core_ct   = 64'hFFFF0000FFFF0000;
        @(negedge ck);
        applyStimulus(1'b0, 64'd0, 1'b1, 64'h9876987698769876);
        doOp("stale", 1'b1, 64'h9876987698769876, 64'd0, 1'b1, TIMEOUT + 1, 1'b1, 1'b1);
        core_mode = 0;
        @(negedge ck);

        // Reset asserted between clock edges 40 cycles into RUN.
        applyStimulus(1'b1, 64'h0F0F0F0F0F0F0F0F, 1'b0, 64'd0);
        #1;
        checkOutput("rstrun_grant", req0_ready, 64'd1);
        @(negedge ck);
        req0_valid = 1'b0;
        repeat (40) @(negedge ck);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rstrun_busy", busy, 64'd0);
        checkOutput("rstrun_core_pt", core_pt, 64'd0);
        checkOutput("rstrun_resp_valid", resp_valid, 64'd0);
        @(negedge ck);
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 120; i++) begin
            @(negedge ck);
            if (resp_valid || busy) seen = 1'b1;
        end
        checkOutput("rstrun_no_resp", seen, 64'd0);
        applyStimulus(1'b1, 64'h1111111111111111, 1'b1, 64'h2222222222222222);
        #1;
        checkOutput("rstrun_rr_reset", {62'd0, req1_ready, req0_ready}, 64'd1);
        @(negedge ck);
        checkOutput("rstrun_core_pt_new", core_pt, 64'h1111111111111111);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
